// File: rtl/pipe_hazard_ctrl.sv
// ID->EX issue controller: register scoreboard for RAW/WAW stalls plus a taken-branch flush sequencer.
// Optional performance counters (stall/flush) are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int NREGS        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rd_we_i,
  input  logic        ex_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        branch_taken_i,
  output logic        issue_o,
  output logic        stall_id_o,
  output logic        flush_o,
  output logic        busy_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             hazard;
  logic             in_run;

  // x0 and indices beyond the register file are never tracked.
  function automatic logic tracked(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  function automatic logic pend_at(input logic [4:0] idx);
    return tracked(idx) && pending_q[idx];
  endfunction

  assign in_run = (state_q == RUN);
  assign hazard = (id_rs1_used_i && pend_at(id_rs1_i))
               || (id_rs2_used_i && pend_at(id_rs2_i))
               || (id_rd_we_i    && pend_at(id_rd_i));

  // State register (synchronous active-low reset).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_q   <= RUN;
      fcnt_q    <= 4'd0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
    end
  end

  // Next-state: flush sequencer and scoreboard.
  // NOTE: each always_comb output is given a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (branch_taken_i && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          fcnt_d  = 4'(FLUSH_CYCLES - 2);
        end
      end
      FLUSH: begin
        if (fcnt_q == 4'd0) state_d = RUN;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase

    // Clear first, then set, so a new writer wins over a same-cycle retirement.
    pending_d = pending_q;
    if (wb_valid_i && tracked(wb_rd_i))
      pending_d[wb_rd_i] = 1'b0;
    if (issue_o && id_rd_we_i && tracked(id_rd_i))
      pending_d[id_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Outputs: all forced low while reset is held.
  always_comb begin
    flush_o    = resetn_i && ((branch_taken_i && in_run) || !in_run);
    issue_o    = resetn_i && id_valid_i && ex_ready_i && in_run && !branch_taken_i && !hazard;
    stall_id_o = resetn_i && id_valid_i && !issue_o && !flush_o;
    busy_o     = resetn_i && (|pending_q);
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_id_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_taken_i && in_run && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, then random traffic against a
// behavioural model (pending-register array plus remaining-flush-cycle count).
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, id_valid, rs1_used, rs2_used, rd_we, ex_ready, wb_valid, br_taken;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic       issue, stall, flush, busy;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.NREGS(32), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .resetn_i      (resetn),
    .id_valid_i    (id_valid),
    .id_rs1_i      (rs1),
    .id_rs2_i      (rs2),
    .id_rs1_used_i (rs1_used),
    .id_rs2_used_i (rs2_used),
    .id_rd_i       (rd),
    .id_rd_we_i    (rd_we),
    .ex_ready_i    (ex_ready),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .branch_taken_i(br_taken),
    .issue_o       (issue),
    .stall_id_o    (stall),
    .flush_o       (flush),
    .busy_o        (busy)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  typedef struct {
    logic       rstn, valid, ready;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we, wbv;
    logic [4:0] wbrd;
    logic       br;
    logic [3:0] exp; // {issue, stall, flush, busy}
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Behavioural model: which registers await writeback, and flush cycles still owed.
  bit m_pend [32];
  int m_flush_left;
`ifdef PIPE_HAZARD_PERF_EN
  int m_stalls, m_flushes;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rstn, valid, ready, input logic [4:0] r1, input logic u1,
                              input logic [4:0] r2, input logic u2, input logic [4:0] d, input logic we,
                              input logic wbv, input logic [4:0] wbrd, input logic br,
                              input logic [3:0] exp);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.ready = ready; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2;
    v.rd = d; v.we = we; v.wbv = wbv; v.wbrd = wbrd; v.br = br; v.exp = exp;
    return v;
  endfunction

  // Apply one cycle: drive, compare mid-cycle, step the model at the rising edge.
  task automatic run_vec(input vec_t v, input bit use_table, input string tag);
    bit haz, m_issue, m_stall, m_flush, m_busy;
    resetn = v.rstn; id_valid = v.valid; ex_ready = v.ready; rs1 = v.rs1; rs1_used = v.u1;
    rs2 = v.rs2; rs2_used = v.u2; rd = v.rd; rd_we = v.we; wb_valid = v.wbv; wb_rd = v.wbrd;
    br_taken = v.br;
    #3;
    haz = (v.u1 && v.rs1 != 0 && m_pend[v.rs1]) || (v.u2 && v.rs2 != 0 && m_pend[v.rs2])
       || (v.we && v.rd != 0 && m_pend[v.rd]);
    m_flush = v.rstn && (v.br || m_flush_left > 0);
    m_issue = v.rstn && v.valid && v.ready && m_flush_left == 0 && !v.br && !haz;
    m_stall = v.rstn && v.valid && !m_issue && !m_flush;
    m_busy  = 1'b0;
    for (int i = 1; i < 32; i++) m_busy |= m_pend[i];
    m_busy &= v.rstn;
    if (use_table) begin
      check({tag, ".issue"}, 32'(issue), 32'(v.exp[3]));
      check({tag, ".stall"}, 32'(stall), 32'(v.exp[2]));
      check({tag, ".flush"}, 32'(flush), 32'(v.exp[1]));
      check({tag, ".busy"},  32'(busy),  32'(v.exp[0]));
    end else begin
      check({tag, ".issue"}, 32'(issue), 32'(m_issue));
      check({tag, ".stall"}, 32'(stall), 32'(m_stall));
      check({tag, ".flush"}, 32'(flush), 32'(m_flush));
      check({tag, ".busy"},  32'(busy),  32'(m_busy));
    end
    @(posedge clk);
    if (!v.rstn) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_flush_left = 0;
`ifdef PIPE_HAZARD_PERF_EN
      m_stalls = 0; m_flushes = 0;
`endif
    end else begin
`ifdef PIPE_HAZARD_PERF_EN
      if (m_stall) m_stalls++;
      if (v.br && m_flush_left == 0) m_flushes++;
`endif
      if (v.wbv && v.wbrd != 0) m_pend[v.wbrd] = 1'b0;
      if (m_issue && v.we && v.rd != 0) m_pend[v.rd] = 1'b1;
      if (m_flush_left > 0) m_flush_left--;
      else if (v.br)        m_flush_left = FC - 1;
    end
    #1;
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    // rstn valid ready rs1 u1 rs2 u2 rd we wbv wbrd br  {issue,stall,flush,busy}
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 4'b0000)); // reset masks outputs
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b1000)); // plain issue rd=5
    tbl.push_back(mk(1, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 4'b0101)); // RAW on x5
    tbl.push_back(mk(1, 1, 1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 4'b0101)); // WB x5 same cycle: still stall
    tbl.push_back(mk(1, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 4'b1000)); // issues next cycle
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 6, 0, 4'b1001)); // x0 rs1/rd never tracked
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'b1000)); // busy stays 0 for x0
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b1000)); // issue rd=7
    tbl.push_back(mk(1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 4'b1001)); // rs2=7 unused: issues
    tbl.push_back(mk(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 4'b0101)); // rs2=7 used: stalls
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 4'b0101)); // WAW on x7
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 4'b1000)); // set/clear x9 same cycle
    tbl.push_back(mk(1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0101)); // set won: stall on x9
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 4'b0001)); // retire x9
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 4'b0010)); // branch T
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 4'b0010)); // T+1, second branch ignored
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 4'b1000)); // T+2 issue resumes
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0101)); // ex not ready: stall
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011)); // branch T, x3 pending
    tbl.push_back(mk(0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // reset in T+1
    tbl.push_back(mk(1, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 4'b1000)); // RUN, scoreboard cleared
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 4'b0001));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));

    // Unchecked reset cycle to bring the DUT out of X.
    resetn = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; rs1 = '0; rs1_used = 1'b0; rs2 = '0;
    rs2_used = 1'b0; rd = '0; rd_we = 1'b0; wb_valid = 1'b0; wb_rd = '0; br_taken = 1'b0;
    m_flush_left = 0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int n = 0; n < 600; n++) begin
      rv.rstn  = ($urandom_range(0, 49) != 0);
      rv.valid = ($urandom_range(0, 3) != 0);
      rv.ready = ($urandom_range(0, 3) != 0);
      rv.rs1   = 5'($urandom_range(0, 7));
      rv.u1    = 1'($urandom);
      rv.rs2   = 5'($urandom_range(0, 7));
      rv.u2    = 1'($urandom);
      rv.rd    = 5'($urandom_range(0, 7));
      rv.we    = 1'($urandom);
      rv.wbv   = 1'($urandom);
      rv.wbrd  = 5'($urandom_range(0, 7));
      rv.br    = ($urandom_range(0, 7) == 0);
      rv.exp   = 4'b0000;
      run_vec(rv, 1'b0, "rand");
    end

`ifdef PIPE_HAZARD_PERF_EN
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), 1'b1, "perf_rst");
    check("stall_cnt_reset", stall_cnt, 32'd0);
    check("flush_cnt_reset", flush_cnt, 32'd0);
    run_vec(mk(1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b1000), 1'b1, "perf_set");
    for (int i = 0; i < 3; i++)
      run_vec(mk(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0101), 1'b1, "perf_stall");
    run_vec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 4'b0011), 1'b1, "perf_br");
    run_vec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0010), 1'b1, "perf_br2");
    run_vec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000), 1'b1, "perf_idle");
    check("stall_cnt", stall_cnt, 32'd3);
    check("flush_cnt", flush_cnt, 32'd1);
    check("stall_cnt_model", stall_cnt, 32'(m_stalls));
    check("flush_cnt_model", flush_cnt, 32'(m_flushes));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Issue controller for the ID→EX boundary of the five-stage core. Owns a register scoreboard and the branch-flush sequencer. Decides each cycle whether the decoded instruction may be handed to the execute stage, stalls decode on RAW/WAW hazards, and kills the front-end after a taken branch reported by execute. Sits beside the decode and execute stages; the execute stage's valid/notify handshake is gated by `issue_o`.

## Interface
- `NREGS`, default 32: architectural register count. x0 is never tracked.
- `FLUSH_CYCLES`, default 2: consecutive cycles `flush_o` is held per taken branch. Legal range is 1–15.
- `clk`  in  1  — clock. All state updates on its rising edge.
- `resetn_i`  in  1  — reset; synchronous, active-low.
- `id_valid_i`  in  1  — decode holds an instruction requesting issue.
- `id_rs1_i`, `id_rs2_i`  in  5 each  — source register indices.
- `id_rs1_used_i`, `id_rs2_used_i`  in  1 each  — the corresponding source is actually read.
- `id_rd_i`  in  5  — destination register index.
- `id_rd_we_i`  in  1  — the instruction writes `id_rd_i`.
- `ex_ready_i`  in  1  — execute stage can accept this cycle (empty, or downstream notify).
- `wb_valid_i`  in  1  — writeback retires a register write this cycle.
- `wb_rd_i`  in  5  — register written by writeback.
- `branch_taken_i`  in  1  — execute resolved a taken branch/jump this cycle.
- `issue_o`  out  1  — ID→EX transfer occurs this cycle.
- `stall_id_o`  out  1  — decode must hold its instruction.
- `flush_o`  out  1  — IF/ID contents are invalid; discard them.
- `busy_o`  out  1  — at least one scoreboard bit is set.
- `stall_cnt_o`  out  32  — present only with `PIPE_HAZARD_PERF_EN`.
- `flush_cnt_o`  out  32  — present only with `PIPE_HAZARD_PERF_EN`.

## Operation
- **Scoreboard:** `pending[NREGS-1:1]`, registered. Index 0 is hard-wired to 0.
- **hazard** = (`id_rs1_used_i` & `pending[id_rs1_i]`) | (`id_rs2_used_i` & `pending[id_rs2_i]`) | (`id_rd_we_i` & `pending[id_rd_i]`). Any term whose index is 0 contributes 0.
- **Issue rule:** `issue_o` = `id_valid_i` & `ex_ready_i` & (state==RUN) & !`branch_taken_i` & !hazard.
- **Stall rule:** `stall_id_o` = `id_valid_i` & !`issue_o` & !`flush_o`.
- **Set:** on `issue_o` & `id_rd_we_i` & rd≠0, set `pending[id_rd_i]`.
- **Clear:** on `wb_valid_i` & `wb_rd_i`≠0, clear `pending[wb_rd_i]`.
- **Set and clear of the same index in one cycle:** set wins, because the new writer owns the register.
- **No WB bypass.** Hazard evaluation uses the registered scoreboard, so a clear takes effect on the following cycle.
- **FSM states:** RUN and FLUSH, with a 4-bit down-counter `fcnt`.
  - RUN → FLUSH: when `branch_taken_i` and `FLUSH_CYCLES` > 1; load `fcnt` = `FLUSH_CYCLES`-2.
  - If `FLUSH_CYCLES` == 1, the FSM stays in RUN.
  - FLUSH: decrement `fcnt`; go to RUN when `fcnt`==0.
  - `branch_taken_i` while in FLUSH is ignored; the counter does not restart.
- **Flush output:** `flush_o` = (`branch_taken_i` & state==RUN) | (state==FLUSH).
- **Busy output:** `busy_o` = OR of `pending`, registered view.
- **Flush does not touch the scoreboard.** Writers already issued will still retire through writeback.

## Timing
- `issue_o`, `stall_id_o`, `flush_o` are combinational from inputs and registered state. Zero-cycle latency.
- Scoreboard and FSM update at the rising edge after the qualifying event.
- **Taken branch in cycle T:** `flush_o` is high in cycles T through T+`FLUSH_CYCLES`-1, and `issue_o` is low in all of them. First issue is possible at cycle T+`FLUSH_CYCLES`.
- **RAW on a register written by writeback in cycle T:** stall through cycle T; issue is possible at T+1.
- **While `resetn_i`==0:** `issue_o`, `stall_id_o`, `flush_o`, `busy_o` are forced to 0.
- **At the first edge with `resetn_i`==0:** `pending`=0, state=RUN, `fcnt`=0, counters=0.
- **Reset asserted mid-flush:** the sequence is abandoned; the block is in RUN after the reset edge.

## Configuration
- Macro: `PIPE_HAZARD_PERF_EN`.
- **Defined:** `stall_cnt_o` and `flush_cnt_o` exist.
  - `stall_cnt_o` increments on every cycle where `stall_id_o`==1.
  - `flush_cnt_o` increments once per accepted branch, i.e. the RUN → flush-start event.
  - Both counters saturate at 0xFFFF_FFFF and clear on reset.
- **Not defined:** both ports and their registers are absent. All other behaviour is identical.

## Test plan
- **Plain issue:** after reset, `id_valid_i`=1, `ex_ready_i`=1, rd=5 with we, no sources → `issue_o`=1 in the same cycle; `busy_o`=1 next cycle.
- **RAW stall:** with x5 pending, present rs1=5 used → `issue_o`=0, `stall_id_o`=1. Then `wb_valid_i`=1, `wb_rd_i`=5 in cycle T → still stalled in T; `issue_o`=1 in T+1.
- **x0 and unused sources:** rd=0 with we set, then rs1=0 used → never stalls, `busy_o` stays 0. Also, x7 pending with rs2=7 and `id_rs2_used_i`=0 → issues.
- **Simultaneous set/clear on x9:** issue with rd=9 while WB clears rd=9 in the same cycle → `pending[9]`=1 afterwards; a following rs1=9 instruction stalls.
- **Branch flush, `FLUSH_CYCLES`=2:** `branch_taken_i` pulse in cycle T with `id_valid_i`=1 → `flush_o`=1 in T and T+1, `issue_o`=0 in both. A second `branch_taken_i` in T+1 is ignored; issue resumes at T+2.
- **Reset mid-flush and perf counters (macro defined):** assert `resetn_i`=0 in T+1 → all outputs 0 and state RUN after the edge. Three stall cycles then one branch → `stall_cnt_o`=3, `flush_cnt_o`=1.
